// File: rtl/minirisc_pkg.sv
// Shared miniRISC definitions: fetch FSM encoding, branch codes, opcode
// constants and instruction field positions.
package minirisc_pkg;

   typedef enum logic [1:0] {
      ST_FETCH  = 2'd0,
      ST_WAIT   = 2'd1,
      ST_EXEC   = 2'd2,
      ST_HALTED = 2'd3
   } fetch_state_t;

   localparam logic [1:0] BR_SEQ    = 2'b00;
   localparam logic [1:0] BR_UNCOND = 2'b01;
   localparam logic [1:0] BR_COND   = 2'b10;
   localparam logic [1:0] BR_CALL   = 2'b11;

   localparam logic [5:0] OP_HALT = 6'b000000;

   localparam int OPC_HI = 31;
   localparam int OPC_LO = 26;
   localparam int IMM_HI = 15;
   localparam int IMM_LO = 0;

   // Width of a counter that must reach max_wait inclusive.
   function automatic int cnt_width(input int max_wait);
      return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
   endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential, relative branch/call target,
// and the return address for call writeback.
module next_pc_calc
   import minirisc_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic [ADDR_W-1:0] pc,
   input  logic [15:0]       imm16,
   input  logic [1:0]        branch,
   input  logic              cond_true,
   output logic [ADDR_W-1:0] next_pc,
   output logic [ADDR_W-1:0] link_pc
);

   logic [ADDR_W-1:0] offset;
   logic [ADDR_W-1:0] target;

   // Signed cast sign-extends for wide PCs and truncates for narrow ones;
   // the add then wraps modulo 2^ADDR_W.
   assign offset  = ADDR_W'($signed(imm16));
   assign link_pc = pc + ADDR_W'(1);
   assign target  = link_pc + offset;

   always_comb begin
      // NOTE: next_pc gets a default before the case so no path leaves it
      // unassigned, which would otherwise infer a latch.
      next_pc = link_pc;
      case (branch)
         BR_SEQ:    next_pc = link_pc;
         BR_UNCOND: next_pc = target;
         BR_COND:   next_pc = cond_true ? target : link_pc;
         BR_CALL:   next_pc = target;
      endcase
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch and sequencing unit: owns the PC, fetches over a
// valid-handshake port, holds the IR through EXEC and halts on HALT/timeout.
module fetch_unit
   import minirisc_pkg::*;
#(
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                MAX_WAIT = 15
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_rdata,
   input  logic              imem_valid,
   output logic [31:0]       instr,
   output logic [5:0]        opcode,
   output logic              instr_valid,
   input  logic [1:0]        branch,
   input  logic              cond_true,
   input  logic              ex_done,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] link_pc,
   output logic              halted,
   output logic              fetch_err
);

   localparam int             CNT_W      = cnt_width(MAX_WAIT);
   localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [31:0]       ir_q, ir_d;
   logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic              fetch_err_q, fetch_err_d;
   logic [ADDR_W-1:0] next_pc;

   next_pc_calc #(.ADDR_W(ADDR_W)) u_next_pc (
      .pc        (pc_q),
      .imm16     (ir_q[IMM_HI:IMM_LO]),
      .branch    (branch),
      .cond_true (cond_true),
      .next_pc   (next_pc),
      .link_pc   (link_pc)
   );

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      ir_d        = ir_q;
      wait_cnt_d  = wait_cnt_q;
      fetch_err_d = fetch_err_q;
      case (state_q)
         ST_FETCH: begin
            wait_cnt_d = '0;
            state_d    = ST_WAIT;
         end
         ST_WAIT: begin
            // A response in the limit cycle still wins over the timeout.
            if (imem_valid) begin
               ir_d    = imem_rdata;
               state_d = ST_EXEC;
            end else if (wait_cnt_q == WAIT_LIMIT) begin
               fetch_err_d = 1'b1;
               state_d     = ST_HALTED;
            end else begin
               wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
         end
         ST_EXEC: begin
            if (ir_q[OPC_HI:OPC_LO] == OP_HALT && ir_q == '0) begin
               state_d = ST_HALTED;
            end else if (ex_done) begin
               pc_d    = next_pc;
               state_d = ST_FETCH;
            end
         end
         ST_HALTED: state_d = ST_HALTED;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples its pre-edge value regardless of statement order.
      if (rst) begin
         state_q     <= ST_FETCH;
         pc_q        <= RESET_PC;
         ir_q        <= '0;
         wait_cnt_q  <= '0;
         fetch_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         ir_q        <= ir_d;
         wait_cnt_q  <= wait_cnt_d;
         fetch_err_q <= fetch_err_d;
      end
   end

   // Request is suppressed while reset is held so it first rises in the
   // cycle after reset releases.
   assign imem_req    = (state_q == ST_FETCH) && !rst;
   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign instr       = ir_q;
   assign opcode      = ir_q[OPC_HI:OPC_LO];
   assign instr_valid = (state_q == ST_EXEC);
   assign halted      = (state_q == ST_HALTED);
   assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a 16-bit instance for sequencing, branches,
// waits, halt, timeout and mid-operation reset, plus a 4-bit instance for wrap.
module tb_fetch_unit;
   import minirisc_pkg::*;

   localparam int MAX_WAIT = 15;

   typedef struct {
      logic [15:0] pc;
      logic [31:0] instr;
   } exp_t;

   logic        clk;
   logic        rst16, rst4;
   logic        sel;
   logic [31:0] imem_rdata;
   logic        imem_valid;
   logic [1:0]  branch;
   logic        cond_true;
   logic        ex_done;

   logic        req16, iv16, halt16, err16;
   logic [15:0] addr16, pc16, link16;
   logic [31:0] instr16;
   logic [5:0]  opc16;

   logic        req4, iv4, halt4, err4;
   logic [3:0]  addr4, pc4, link4;
   logic [31:0] instr4;
   logic [5:0]  opc4;

   logic        req_s, iv_s, halt_s, err_s;
   logic [15:0] addr_s, pc_s, link_s, mask_s, reset_pc_s;
   logic [31:0] instr_s;
   logic [5:0]  opc_s;

   int          checks   = 0;
   int          failures = 0;
   logic [15:0] model_pc;
   exp_t        sb[$];

   fetch_unit #(.ADDR_W(16), .RESET_PC(16'd0), .MAX_WAIT(MAX_WAIT)) dut16 (
      .clk(clk), .rst(rst16), .imem_req(req16), .imem_addr(addr16),
      .imem_rdata(imem_rdata), .imem_valid(imem_valid), .instr(instr16),
      .opcode(opc16), .instr_valid(iv16), .branch(branch), .cond_true(cond_true),
      .ex_done(ex_done), .pc(pc16), .link_pc(link16), .halted(halt16),
      .fetch_err(err16)
   );

   fetch_unit #(.ADDR_W(4), .RESET_PC(4'd14), .MAX_WAIT(MAX_WAIT)) dut4 (
      .clk(clk), .rst(rst4), .imem_req(req4), .imem_addr(addr4),
      .imem_rdata(imem_rdata), .imem_valid(imem_valid), .instr(instr4),
      .opcode(opc4), .instr_valid(iv4), .branch(branch), .cond_true(cond_true),
      .ex_done(ex_done), .pc(pc4), .link_pc(link4), .halted(halt4),
      .fetch_err(err4)
   );

   assign req_s      = sel ? req4 : req16;
   assign iv_s       = sel ? iv4 : iv16;
   assign halt_s     = sel ? halt4 : halt16;
   assign err_s      = sel ? err4 : err16;
   assign addr_s     = sel ? {12'd0, addr4} : addr16;
   assign pc_s       = sel ? {12'd0, pc4} : pc16;
   assign link_s     = sel ? {12'd0, link4} : link16;
   assign instr_s    = sel ? instr4 : instr16;
   assign opc_s      = sel ? opc4 : opc16;
   assign mask_s     = sel ? 16'h000F : 16'hFFFF;
   assign reset_pc_s = sel ? 16'd14 : 16'd0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] model_next(input logic [15:0] p, input logic [31:0] w,
                                              input logic [1:0] br, input logic c,
                                              input logic [15:0] m);
      logic [15:0] seq, tgt;
      seq = (p + 16'd1) & m;
      tgt = (p + 16'd1 + w[15:0]) & m;
      case (br)
         2'b00:   return seq;
         2'b10:   return c ? tgt : seq;
         default: return tgt;
      endcase
   endfunction

   task automatic do_reset();
      imem_valid = 1'b0;
      ex_done    = 1'b0;
      if (sel) rst4 = 1'b1; else rst16 = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_pc", pc_s, reset_pc_s);
      check("rst_instr", instr_s, 32'd0);
      check("rst_opcode", opc_s, 6'd0);
      check("rst_flags", {iv_s, req_s, halt_s, err_s}, 4'b0000);
      if (sel) rst4 = 1'b0; else rst16 = 1'b0;
      #1;
      check("first_req", req_s, 1'b1);
      model_pc = reset_pc_s;
   endtask

   task automatic wait_req(output int n);
      n = 0;
      while (!req_s && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("req_seen", req_s, 1'b1);
   endtask

   // One full instruction: FETCH, `lat` WAIT cycles, EXEC held `ex_delay` cycles.
   task automatic run_instr(input logic [31:0] w, input int lat, input logic [1:0] br,
                            input logic c, input int ex_delay);
      int   n;
      exp_t e;
      wait_req(n);
      check("req_period", n, 0);
      check("imem_addr", addr_s, model_pc);
      for (int k = 1; k <= lat; k++) begin
         @(negedge clk);
         check("in_wait", {iv_s, req_s, halt_s}, 3'b000);
      end
      imem_rdata = w;
      imem_valid = 1'b1;
      sb.push_back('{pc: model_pc, instr: w});
      @(negedge clk);
      imem_valid = 1'b0;
      imem_rdata = $urandom;
      e = sb.pop_front();
      check("instr", instr_s, e.instr);
      check("opcode", opc_s, e.instr[31:26]);
      check("exec_pc", pc_s, e.pc);
      check("instr_valid", iv_s, 1'b1);
      check("link_pc", link_s, (e.pc + 16'd1) & mask_s);
      branch    = br;
      cond_true = c;
      for (int d = 0; d < ex_delay; d++) begin
         ex_done = 1'b0;
         @(negedge clk);
         check("exec_hold", {iv_s, pc_s}, {1'b1, e.pc});
      end
      ex_done = 1'b1;
      model_pc = model_next(e.pc, e.instr, br, c, mask_s);
      @(negedge clk);
      ex_done = 1'b0;
      check("next_pc", pc_s, model_pc);
   endtask

   initial begin
      int n;
      int reqs;
      rst16 = 1'b1; rst4 = 1'b1; sel = 1'b0;
      imem_rdata = '0; imem_valid = 1'b0; branch = BR_SEQ; cond_true = 1'b0; ex_done = 1'b0;

      do_reset();
      run_instr(32'h04000001, 1, BR_SEQ, 1'b0, 0);
      run_instr(32'h08000002, 1, BR_SEQ, 1'b0, 0);
      check("seq_pc2", pc_s, 16'd2);

      run_instr(32'h0C000002, 1, BR_UNCOND, 1'b0, 2);
      check("to_pc5", pc_s, 16'd5);
      run_instr(32'h0C00FFFE, 1, BR_UNCOND, 1'b0, 0);
      check("uncond_back", pc_s, 16'd4);
      run_instr(32'h10000000, 1, BR_SEQ, 1'b0, 0);
      run_instr(32'h1000FFFE, 1, BR_COND, 1'b0, 0);
      check("cond_not_taken", pc_s, 16'd6);
      run_instr(32'h0C00FFFE, 1, BR_UNCOND, 1'b0, 0);
      run_instr(32'h1400FFFE, 1, BR_CALL, 1'b0, 0);
      check("call_target", pc_s, 16'd4);
      run_instr(32'h10000003, 1, BR_COND, 1'b1, 0);
      check("cond_taken", pc_s, 16'd8);

      run_instr(32'h18000000, 4, BR_SEQ, 1'b0, 0);
      check("wait4_no_err", err_s, 1'b0);

      // HALT instruction at pc 9: ex_done with a taken branch must be ignored.
      wait_req(n);
      @(negedge clk);
      imem_rdata = 32'h0; imem_valid = 1'b1;
      @(negedge clk);
      imem_valid = 1'b0;
      check("halt_exec", {iv_s, halt_s}, 2'b10);
      branch = BR_UNCOND; ex_done = 1'b1;
      @(negedge clk);
      ex_done = 1'b0;
      check("halt_state", {halt_s, iv_s, req_s}, 3'b100);
      check("halt_pc", pc_s, 16'd9);
      reqs = 0;
      for (int k = 0; k < 8; k++) begin
         imem_valid = k[0]; ex_done = ~k[0];
         @(negedge clk);
         if (req_s) reqs++;
      end
      imem_valid = 1'b0; ex_done = 1'b0;
      check("halt_no_req", reqs, 0);
      check("halt_absorb", halt_s, 1'b1);

      do_reset();

      // Reset while WAIT sees a response: IR must not capture it.
      wait_req(n);
      @(negedge clk);
      imem_rdata = 32'hDEADBEEF; imem_valid = 1'b1; rst16 = 1'b1;
      @(negedge clk);
      imem_valid = 1'b0;
      check("rst_wait_ir", instr_s, 32'd0);
      check("rst_wait_flags", {iv_s, req_s, pc_s}, {2'b00, 16'd0});
      rst16 = 1'b0;
      #1;
      check("rst_wait_req", req_s, 1'b1);
      model_pc = 16'd0;

      // Reset in EXEC together with ex_done: PC must not advance.
      run_instr(32'h04000001, 1, BR_SEQ, 1'b0, 0);
      wait_req(n);
      @(negedge clk);
      imem_rdata = 32'h0C000005; imem_valid = 1'b1;
      @(negedge clk);
      imem_valid = 1'b0;
      check("rst_exec_pre", {iv_s, pc_s}, {1'b1, 16'd1});
      branch = BR_UNCOND; ex_done = 1'b1; rst16 = 1'b1;
      @(negedge clk);
      ex_done = 1'b0;
      check("rst_exec_pc", pc_s, 16'd0);
      check("rst_exec_ir", instr_s, 32'd0);
      check("rst_exec_iv", iv_s, 1'b0);
      rst16 = 1'b0;
      #1;
      model_pc = 16'd0;

      // Memory never answers: timeout after MAX_WAIT-bounded stretch.
      wait_req(n);
      n = 0;
      while (!halt_s && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("timeout_halt", halt_s, 1'b1);
      check("timeout_err", err_s, 1'b1);
      check("timeout_window", (n > MAX_WAIT) && (n <= MAX_WAIT + 2), 1'b1);
      reqs = 0;
      for (int k = 0; k < 10; k++) begin
         imem_valid = k[0];
         @(negedge clk);
         if (req_s) reqs++;
      end
      imem_valid = 1'b0;
      check("timeout_no_req", reqs, 0);
      check("timeout_err_sticky", err_s, 1'b1);
      do_reset();

      // Narrow instance: PC wrap in both the sequential and target paths.
      rst16 = 1'b1;
      sel   = 1'b1;
      do_reset();
      run_instr(32'h0C000002, 1, BR_UNCOND, 1'b0, 0);
      check("wrap_target", pc_s, 16'd1);
      run_instr(32'h0C00FFFD, 1, BR_UNCOND, 1'b0, 0);
      check("wrap_neg", pc_s, 16'd15);
      run_instr(32'h10000000, 1, BR_SEQ, 1'b0, 0);
      check("wrap_seq", pc_s, 16'd0);
      check("sb_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
